elbeth_lsu_mem_if: RTL and testbench
====================================

Name: elbeth_lsu_mem_if

Overview:
- Load/store interface stage between the core's memory-access pipeline stage and one port (normally port B) of the dual-port data RAM.
- Accepts one byte/half/word load or store request at a time.
- Checks alignment and address range, generates the 4-bit byte-lane write mask and lane-replicated store data, and drives a one-cycle RAM enable pulse.
- Waits for the RAM ready flag, then returns sign- or zero-extended load data to the core with a single-cycle response strobe; a timeout flags an absent ready.

Parameters:
AW, 12, RAM word-address width; valid byte addresses are 0 .. 2^(AW+2)-1.
TIMEOUT, 4, cycles WAIT tolerates without mem_ready before a bus error (1..255).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  reset, asynchronous, active-low
req_valid  in  1  core request strobe
req_ready  out  1  block can accept a request (combinational, high only in IDLE)
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
req_we  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err_align  out  1  misaligned or illegal-size request (valid with resp_valid)
resp_err_bus  out  1  out-of-range address or timeout (valid with resp_valid)
mem_enable  out  1  RAM port enable
mem_addr  out  AW  RAM word address = addr[AW+1:2]
mem_data_in  out  32  lane-replicated store data
mem_rw  out  4  byte write mask; 0000 for loads
mem_data_out  in  32  RAM read data, valid while mem_ready = 1
mem_ready  in  1  RAM ready; goes high the cycle after mem_enable

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE and timeout counter 0.
- Reset values of all outputs: resp_valid 0, resp_rdata 0, resp_err_align 0, resp_err_bus 0, mem_enable 0, mem_addr 0, mem_data_in 0, mem_rw 0.
- Reset mid-transaction aborts immediately: mem_enable drops asynchronously and no response is produced.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch addr, wdata, we, size and unsigned.
  - Alignment error when size = 11, or size = 01 with addr[0] = 1, or size = 10 with addr[1:0] != 0.
  - Range error when addr[31:AW+2] != 0. If both errors apply, alignment takes priority.
  - Any error: go to RESP with the matching error flag; no RAM access.
  - Otherwise go to ACCESS.
- ACCESS (exactly 1 cycle):
  - mem_enable = 1; mem_addr = addr[AW+1:2].
  - Loads: mem_rw = 0000.
  - SB: mem_rw = 0001 << addr[1:0]; mem_data_in = 4 copies of wdata[7:0].
  - SH: mem_rw = 0011 if addr[1] = 0, else 1100; mem_data_in = 2 copies of wdata[15:0].
  - SW: mem_rw = 1111; mem_data_in = wdata.
  - Go to WAIT with counter cleared.
- WAIT:
  - mem_enable = 0 and mem_rw = 0000; mem_addr and mem_data_in hold.
  - If mem_ready = 1: capture the extracted and extended lane into resp_rdata (0 for stores), then go to RESP.
  - Load extraction: byte lane = addr[1:0]; half lane = addr[1]. Bit 7 or bit 15 of the lane selects the sign extension unless unsigned is set.
  - Else if counter = TIMEOUT-1: set resp_err_bus, resp_rdata = 0, go to RESP.
  - Else counter increments.
- RESP:
  - resp_valid = 1 for exactly one cycle, with resp_rdata and error flags stable during it.
  - Then return to IDLE, clearing the error flags and resp_rdata on that transition.
- Latency (nominal RAM): request accepted at edge 0, ACCESS during cycle 1, mem_ready seen in cycle 2, resp_valid in cycle 3. Error responses arrive in cycle 1.
- req_valid outside IDLE is ignored (req_ready = 0); the core holds the request.
- A new request is accepted in the same cycle req_ready returns high; the sustained rate is one transaction per 4 cycles.
- mem_ready seen outside WAIT is ignored.

Test Plan:
- SW 0x0000_0010 data 0xDEADBEEF, then LW same address: mem_rw = 1111 for one cycle with mem_addr = 0x004; load resp_rdata = 0xDEADBEEF, resp_valid in the 3rd cycle after acceptance, no error flags.
- SB 0x13 data 0x0000_00A5, then LB 0x13 and LBU 0x13: mem_rw = 1000, mem_data_in = 0xA5A5A5A5; LB returns 0xFFFFFFA5, LBU returns 0x000000A5.
- SH 0x22 data 0x8001, then LH and LHU at 0x22: mem_rw = 1100; LH returns 0xFFFF8001, LHU returns 0x00008001.
- LW at 0x6 and LH at 0x5 -> resp_valid in cycle 1 with resp_err_align = 1, resp_rdata = 0, mem_enable never asserted. req_size = 11 also -> resp_err_align = 1.
- Load at 0x0000_4000 with AW = 12 -> resp_err_bus = 1 and no RAM access. Separately, mem_ready tied low -> resp_err_bus after exactly TIMEOUT (4) WAIT cycles.
- rst pulsed low during WAIT -> all outputs 0 immediately, no resp_valid. Next request completes normally; req_valid held during a transaction is not re-accepted until RESP ends.

Source files
------------

// File: rtl/elbeth_lsu_mem_if_if.sv
// Bundle of core-side request/response and RAM-port signals for the LSU memory interface.
// The LSU owns the slave view; the core plus RAM environment owns the master view.
interface elbeth_lsu_mem_if_if #(
    parameter int AW = 12
);
    // Request handshake: a request transfers on a rising edge where req_valid and req_ready
    // are both high. The core holds every req_* field stable while req_valid is high and
    // req_ready is low. resp_valid is a single-cycle strobe that the core cannot stall.
    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic          resp_err_align;
    logic          resp_err_bus;
    logic          mem_enable;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data_in;
    logic [3:0]    mem_rw;
    logic [31:0]   mem_data_out;
    logic          mem_ready;

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_size, req_unsigned,
        input  mem_data_out, mem_ready,
        output req_ready, resp_valid, resp_rdata, resp_err_align, resp_err_bus,
        output mem_enable, mem_addr, mem_data_in, mem_rw
    );

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_size, req_unsigned,
        output mem_data_out, mem_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err_align, resp_err_bus,
        input  mem_enable, mem_addr, mem_data_in, mem_rw
    );
endinterface

// File: rtl/elbeth_lsu_mem_if.sv
// Load/store stage between the core memory-access stage and one data-RAM port:
// checks alignment and range, builds byte masks, waits for RAM ready, extends load data.
module elbeth_lsu_mem_if #(
    parameter int AW      = 12,
    parameter int TIMEOUT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    elbeth_lsu_mem_if_if.slave     bus,
    output logic [1:0]             dbg_state
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]  state;
    logic [7:0]  cnt;
    logic [1:0]  addr_q;
    logic [1:0]  size_q;
    logic        we_q;
    logic        uns_q;

    logic        err_align;
    logic        err_range;
    logic [3:0]  mask_d;
    logic [31:0] din_d;
    logic [31:0] lane;
    logic [31:0] load_val;

    // Request decode, evaluated on the live request while IDLE.
    always_comb begin
        err_align = 1'b0;
        case (bus.req_size)
            2'b00:   err_align = 1'b0;
            2'b01:   err_align = bus.req_addr[0];
            2'b10:   err_align = |bus.req_addr[1:0];
            default: err_align = 1'b1;
        endcase
        err_range = (bus.req_addr >> (AW + 2)) != 32'd0;

        mask_d = 4'b0000;
        din_d  = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                mask_d = 4'b0001 << bus.req_addr[1:0];
                din_d  = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                mask_d = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                din_d  = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                mask_d = 4'b1111;
                din_d  = bus.req_wdata;
            end
        endcase
        if (!bus.req_we) mask_d = 4'b0000;
    end

    // Alignment guarantees the shifted lane starts at bit 0 for every legal size.
    always_comb begin
        lane     = bus.mem_data_out >> {addr_q, 3'b000};
        load_val = lane;
        case (size_q)
            2'b00:   load_val = {{24{~uns_q & lane[7]}}, lane[7:0]};
            2'b01:   load_val = {{16{~uns_q & lane[15]}}, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= S_IDLE;
            cnt                <= 8'd0;
            addr_q             <= 2'b00;
            size_q             <= 2'b00;
            we_q               <= 1'b0;
            uns_q              <= 1'b0;
            bus.resp_rdata     <= 32'd0;
            bus.resp_err_align <= 1'b0;
            bus.resp_err_bus   <= 1'b0;
            bus.mem_enable     <= 1'b0;
            bus.mem_addr       <= '0;
            bus.mem_data_in    <= 32'd0;
            bus.mem_rw         <= 4'b0000;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        addr_q <= bus.req_addr[1:0];
                        size_q <= bus.req_size;
                        we_q   <= bus.req_we;
                        uns_q  <= bus.req_unsigned;
                        if (err_align) begin
                            bus.resp_err_align <= 1'b1;
                            state              <= S_RESP;
                        end else if (err_range) begin
                            bus.resp_err_bus <= 1'b1;
                            state            <= S_RESP;
                        end else begin
                            bus.mem_enable  <= 1'b1;
                            bus.mem_addr    <= bus.req_addr[AW+1:2];
                            bus.mem_data_in <= din_d;
                            bus.mem_rw      <= mask_d;
                            state           <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    bus.mem_enable <= 1'b0;
                    bus.mem_rw     <= 4'b0000;
                    cnt            <= 8'd0;
                    state          <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.mem_ready) begin
                        bus.resp_rdata <= we_q ? 32'd0 : load_val;
                        state          <= S_RESP;
                    end else if (cnt == 8'(TIMEOUT - 1)) begin
                        bus.resp_err_bus <= 1'b1;
                        bus.resp_rdata   <= 32'd0;
                        state            <= S_RESP;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                    bus.resp_rdata     <= 32'd0;
                    bus.resp_err_align <= 1'b0;
                    bus.resp_err_bus   <= 1'b0;
                    state              <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.resp_valid = (state == S_RESP);
    assign dbg_state      = state;
endmodule

// File: tb/tb_elbeth_lsu_mem_if.sv
// Directed bench for elbeth_lsu_mem_if with a small behavioural RAM answering one cycle
// after each enable pulse; every expected value is hand-computed.
module tb_elbeth_lsu_mem_if;
    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    elbeth_lsu_mem_if_if #(.AW(12)) bus ();

    elbeth_lsu_mem_if #(.AW(12), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: read data and ready appear the cycle after enable.
    logic [31:0] ram [0:4095];
    logic        ready_q = 1'b0;
    logic [31:0] rdata_q = 32'd0;
    logic        ram_ready_en = 1'b1;

    always @(posedge clk) begin
        ready_q <= bus.mem_enable & ram_ready_en;
        if (bus.mem_enable) begin
            rdata_q <= ram[bus.mem_addr];
            for (int b = 0; b < 4; b++)
                if (bus.mem_rw[b]) ram[bus.mem_addr][8*b +: 8] <= bus.mem_data_in[8*b +: 8];
        end
    end
    assign bus.mem_ready    = ready_q;
    assign bus.mem_data_out = rdata_q;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    int          r_lat;
    int          r_ens;
    logic        r_busy;
    logic        r_post;
    logic [3:0]  r_rw;
    logic [31:0] r_din;
    logic [11:0] r_maddr;
    logic [31:0] r_rdata;
    logic        r_ea;
    logic        r_eb;

    task automatic run(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic hold);
        int guard;
        guard = 0;
        while (!bus.req_ready && guard < 10) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!bus.req_ready) check("ready_wait", 32'd0, 32'd1);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = size;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wdata;
        @(posedge clk); #1;
        if (!hold) bus.req_valid = 1'b0;
        r_lat = 0; r_ens = 0; r_busy = 1'b0; r_rw = 4'b0; r_din = 32'd0; r_maddr = 12'd0;
        r_rdata = 32'd0; r_ea = 1'b0; r_eb = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (bus.mem_enable) begin
                r_ens++;
                r_rw    = bus.mem_rw;
                r_din   = bus.mem_data_in;
                r_maddr = bus.mem_addr;
            end
            if (bus.resp_valid) begin
                r_lat   = c;
                r_rdata = bus.resp_rdata;
                r_ea    = bus.resp_err_align;
                r_eb    = bus.resp_err_bus;
                bus.req_valid = 1'b0;
                break;
            end
            if (bus.req_ready) r_busy = 1'b1;
            @(posedge clk); #1;
        end
        if (r_lat == 0) check("resp_timeout", 32'd0, 32'd1);
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        r_post = bus.resp_valid;
    endtask

    logic seen_resp;

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'd0;
        rst              = 1'b0;
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 32'd0;
        bus.req_wdata    = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_mem_enable", 32'(bus.mem_enable), 32'd0);
        check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_mem_rw", 32'(bus.mem_rw), 32'd0);
        check("rst_mem_data_in", bus.mem_data_in, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata, 32'd0);
        check("rst_errs", 32'({bus.resp_err_align, bus.resp_err_bus}), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_req_ready", 32'(bus.req_ready), 32'd1);

        run(1'b1, 2'b10, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        check("sw_rw", 32'(r_rw), 32'hF);
        check("sw_addr", 32'(r_maddr), 32'h004);
        check("sw_din", r_din, 32'hDEAD_BEEF);
        check("sw_ens", 32'(r_ens), 32'd1);
        check("sw_lat", 32'(r_lat), 32'd3);
        check("sw_rdata", r_rdata, 32'd0);
        check("sw_errs", 32'({r_ea, r_eb}), 32'd0);
        check("sw_one_cycle", 32'(r_post), 32'd0);

        run(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
        check("lw_rdata", r_rdata, 32'hDEAD_BEEF);
        check("lw_lat", 32'(r_lat), 32'd3);
        check("lw_rw", 32'(r_rw), 32'h0);
        check("lw_errs", 32'({r_ea, r_eb}), 32'd0);

        run(1'b1, 2'b00, 1'b0, 32'h0000_0013, 32'h0000_00A5, 1'b0);
        check("sb_rw", 32'(r_rw), 32'h8);
        check("sb_din", r_din, 32'hA5A5_A5A5);
        run(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'd0, 1'b0);
        check("lb_rdata", r_rdata, 32'hFFFF_FFA5);
        run(1'b0, 2'b00, 1'b1, 32'h0000_0013, 32'd0, 1'b0);
        check("lbu_rdata", r_rdata, 32'h0000_00A5);

        run(1'b1, 2'b01, 1'b0, 32'h0000_0022, 32'h0000_8001, 1'b0);
        check("sh_rw", 32'(r_rw), 32'hC);
        check("sh_din", r_din, 32'h8001_8001);
        run(1'b0, 2'b01, 1'b0, 32'h0000_0022, 32'd0, 1'b0);
        check("lh_rdata", r_rdata, 32'hFFFF_8001);
        run(1'b0, 2'b01, 1'b1, 32'h0000_0022, 32'd0, 1'b0);
        check("lhu_rdata", r_rdata, 32'h0000_8001);

        run(1'b0, 2'b10, 1'b0, 32'h0000_0006, 32'd0, 1'b0);
        check("lw_mis_lat", 32'(r_lat), 32'd1);
        check("lw_mis_errs", 32'({r_ea, r_eb}), 32'h2);
        check("lw_mis_rdata", r_rdata, 32'd0);
        check("lw_mis_ens", 32'(r_ens), 32'd0);
        run(1'b0, 2'b01, 1'b0, 32'h0000_0005, 32'd0, 1'b0);
        check("lh_mis_errs", 32'({r_ea, r_eb}), 32'h2);
        check("lh_mis_ens", 32'(r_ens), 32'd0);
        run(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'd0, 1'b0);
        check("size11_errs", 32'({r_ea, r_eb}), 32'h2);

        run(1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'd0, 1'b0);
        check("range_errs", 32'({r_ea, r_eb}), 32'h1);
        check("range_lat", 32'(r_lat), 32'd1);
        check("range_ens", 32'(r_ens), 32'd0);
        run(1'b0, 2'b10, 1'b0, 32'h0000_4001, 32'd0, 1'b0);
        check("both_err_prio", 32'({r_ea, r_eb}), 32'h2);

        ram_ready_en = 1'b0;
        run(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 1'b0);
        check("tmo_lat", 32'(r_lat), 32'd6);
        check("tmo_errs", 32'({r_ea, r_eb}), 32'h1);
        check("tmo_rdata", r_rdata, 32'd0);
        check("tmo_ens", 32'(r_ens), 32'd1);

        // Abort a store parked in WAIT with an asynchronous reset.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h0000_0040;
        bus.req_wdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_rst_state", 32'(dbg_state), 32'd2);
        #2 rst = 1'b0;
        #1;
        check("arst_mem_enable", 32'(bus.mem_enable), 32'd0);
        check("arst_mem_addr", 32'(bus.mem_addr), 32'd0);
        check("arst_mem_data_in", bus.mem_data_in, 32'd0);
        check("arst_mem_rw", 32'(bus.mem_rw), 32'd0);
        check("arst_resp", 32'({bus.resp_valid, bus.resp_err_align, bus.resp_err_bus}), 32'd0);
        check("arst_rdata", bus.resp_rdata, 32'd0);
        check("arst_state", 32'(dbg_state), 32'd0);
        seen_resp = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (c == 1) rst = 1'b1;
            if (bus.resp_valid) seen_resp = 1'b1;
        end
        check("arst_no_resp", 32'(seen_resp), 32'd0);
        ram_ready_en = 1'b1;

        run(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'd0, 1'b1);
        check("held_rdata", r_rdata, 32'hA5AD_BEEF);
        check("held_lat", 32'(r_lat), 32'd3);
        check("held_ens", 32'(r_ens), 32'd1);
        check("held_busy", 32'(r_busy), 32'd0);
        check("held_errs", 32'({r_ea, r_eb}), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=0x00000000 exp=0x00000001");
        $fatal(1, "simulation time limit");
    end
endmodule
